// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, branch conditions
// and the condition-code flag bundle.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] ADD = 4'h0;
    localparam logic [3:0] SUB = 4'h1;
    localparam logic [3:0] AND = 4'h2;
    localparam logic [3:0] XOR = 4'h3;

    localparam logic [3:0] ALWAYS = 4'h0;
    localparam logic [3:0] LE     = 4'h1;
    localparam logic [3:0] L      = 4'h2;
    localparam logic [3:0] E      = 4'h3;
    localparam logic [3:0] NE     = 4'h4;
    localparam logic [3:0] GE     = 4'h5;
    localparam logic [3:0] G      = 4'h6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/execute_if.sv
// Decode-to-execute operand bundle plus the execute results fed onward.
interface execute_if;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        Cnd;

    modport master (
        output icode, ifun, valA, valB, valC,
        input  valE, Cnd
    );

    modport slave (
        input  icode, ifun, valA, valB, valC,
        output valE, Cnd
    );
endinterface

// File: rtl/y86_alu.sv
// 64-bit Y86 ALU: add/sub/and/xor on aluB op aluA with ZF/SF/OF flags.
// Unknown function codes give a zero result with OF clear.
module y86_alu
    import y86_pkg::*;
(
    input  logic [63:0] aluA,
    input  logic [63:0] aluB,
    input  logic [3:0]  alufun,
    output logic [63:0] result,
    output logic        zf,
    output logic        sf,
    output logic        of
);

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (alufun)
            ADD: begin
                result = aluB + aluA;
                of     = (aluA[63] == aluB[63]) && (result[63] != aluB[63]);
            end
            SUB: begin
                result = aluB - aluA;
                of     = (aluA[63] != aluB[63]) && (result[63] != aluB[63]);
            end
            AND:     result = aluB & aluA;
            XOR:     result = aluB ^ aluA;
            default: result = '0;
        endcase
    end

    assign zf = (result == 64'd0);
    assign sf = result[63];

endmodule

// File: rtl/execute.sv
// SEQ Y86-64 execute stage: operand selection into the ALU, the ZF/SF/OF
// condition-code register, and the Cnd flag for jumps and conditional moves.
module execute
    import y86_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    execute_if.slave     bus
);

    logic [63:0] w_alu_a;
    logic [63:0] w_alu_b;
    logic [3:0]  w_alu_fun;
    logic [63:0] w_result;
    logic        w_zf;
    logic        w_sf;
    logic        w_of;
    logic        w_cc_load;
    logic        w_cnd;
    logic        w_sf_xor_of;
    cc_t         r_cc;

    // Every icode is routed through the single adder; opcodes with no
    // arithmetic feed 0 + 0 so valE is always defined.
    always_comb begin
        w_alu_a   = '0;
        w_alu_b   = '0;
        w_alu_fun = ADD;
        case (bus.icode)
            CMOVXX:         w_alu_a = bus.valA;
            IRMOVQ:         w_alu_a = bus.valC;
            RMMOVQ, MRMOVQ: begin
                w_alu_a = bus.valC;
                w_alu_b = bus.valB;
            end
            OPQ: begin
                w_alu_a   = bus.valA;
                w_alu_b   = bus.valB;
                w_alu_fun = bus.ifun;
            end
            CALL, PUSHQ: begin
                w_alu_a   = 64'd8;
                w_alu_b   = bus.valB;
                w_alu_fun = SUB;
            end
            RET, POPQ: begin
                w_alu_a = 64'd8;
                w_alu_b = bus.valB;
            end
            default: ;
        endcase
    end

    y86_alu u_alu (
        .aluA   (w_alu_a),
        .aluB   (w_alu_b),
        .alufun (w_alu_fun),
        .result (w_result),
        .zf     (w_zf),
        .sf     (w_sf),
        .of     (w_of)
    );

    assign w_cc_load = (bus.icode == OPQ) && (bus.ifun <= XOR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc <= CC_RESET;
        end else if (w_cc_load) begin
            r_cc <= '{zf: w_zf, sf: w_sf, of: w_of};
        end
    end

    // Conditions read the registered flags, so an OPq is only visible to
    // the instruction in the following cycle.
    assign w_sf_xor_of = r_cc.sf ^ r_cc.of;

    always_comb begin
        w_cnd = 1'b0;
        if (bus.icode == CMOVXX || bus.icode == JXX) begin
            case (bus.ifun)
                ALWAYS:  w_cnd = 1'b1;
                LE:      w_cnd = w_sf_xor_of | r_cc.zf;
                L:       w_cnd = w_sf_xor_of;
                E:       w_cnd = r_cc.zf;
                NE:      w_cnd = ~r_cc.zf;
                GE:      w_cnd = ~w_sf_xor_of;
                G:       w_cnd = ~w_sf_xor_of & ~r_cc.zf;
                default: w_cnd = 1'b0;
            endcase
        end
    end

    assign bus.valE = w_result;
    assign bus.Cnd  = w_cnd;

endmodule

// File: tb/tb_execute.sv
// Bench for the execute stage: directed plan steps with hand-derived
// expectations, then random traffic checked against a reference model.
module tb_execute;
    import y86_pkg::*;

    typedef struct {
        string       tag;
        logic [63:0] val_e;
        logic        cnd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    // Reference copy of the condition codes, advanced once per applied cycle
    logic m_zf = 1'b1;
    logic m_sf = 1'b0;
    logic m_of = 1'b0;

    execute_if bus ();

    execute dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] model_val_e(input logic [3:0] ic, input logic [3:0] fn,
                                                input logic [63:0] a, input logic [63:0] b,
                                                input logic [63:0] c);
        case (ic)
            4'h2:       return a;
            4'h3:       return c;
            4'h4, 4'h5: return b + c;
            4'h6: case (fn)
                4'h0:    return b + a;
                4'h1:    return b - a;
                4'h2:    return b & a;
                4'h3:    return b ^ a;
                default: return 64'd0;
            endcase
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            default:    return 64'd0;
        endcase
    endfunction

    function automatic logic model_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic zf, input logic sf, input logic of);
        if (ic != 4'h2 && ic != 4'h7) return 1'b0;
        case (fn)
            4'h0:    return 1'b1;
            4'h1:    return (sf ^ of) | zf;
            4'h2:    return sf ^ of;
            4'h3:    return zf;
            4'h4:    return !zf;
            4'h5:    return !(sf ^ of);
            4'h6:    return !(sf ^ of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // One cycle: drive on the falling edge, check the combinational outputs,
    // then advance the model flags for the rising edge that follows.
    task automatic apply(input string tag, input logic r, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [63:0] exp_e, input logic exp_c);
        exp_t        ent;
        logic [63:0] res;
        @(negedge clk);
        rst       = r;
        bus.icode = ic;
        bus.ifun  = fn;
        bus.valA  = a;
        bus.valB  = b;
        bus.valC  = c;
        sb.push_back('{tag: tag, val_e: exp_e, cnd: exp_c});
        #1;
        ent = sb.pop_front();
        check({ent.tag, ".valE"}, bus.valE, ent.val_e);
        check({ent.tag, ".Cnd"}, {63'd0, bus.Cnd}, {63'd0, ent.cnd});
        $display("txn %-10s rst=%b icode=%h ifun=%h valE=%h Cnd=%b", tag, r, ic, fn, bus.valE, bus.Cnd);
        if (r) begin
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        end else if (ic == 4'h6 && fn <= 4'h3) begin
            res  = model_val_e(ic, fn, a, b, c);
            m_zf = (res == 64'd0);
            m_sf = res[63];
            if (fn == 4'h0)      m_of = (a[63] == b[63]) && (res[63] != b[63]);
            else if (fn == 4'h1) m_of = (a[63] != b[63]) && (res[63] != b[63]);
            else                 m_of = 1'b0;
        end
    endtask

    initial begin
        logic [3:0]  ic, fn;
        logic [63:0] a, b, c;
        logic        r;

        bus.icode = 4'h1; bus.ifun = 4'h0;
        bus.valA = '0; bus.valB = '0; bus.valC = '0;

        // Reset state
        apply("rst",     1'b1, NOP, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        apply("je_rst",  1'b0, JXX, E,    64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        apply("jne_rst", 1'b0, JXX, NE,   64'd0, 64'd0, 64'd0, 64'd0, 1'b0);

        // Subtract 50-10: all flags clear
        apply("sub40",   1'b0, OPQ, SUB,  64'd10, 64'd50, 64'd20, 64'd40, 1'b0);
        apply("jne_40",  1'b0, JXX, NE,   64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        apply("jl_40",   1'b0, JXX, L,    64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        apply("jle_40",  1'b0, JXX, LE,   64'd0, 64'd0, 64'd0, 64'd0, 1'b0);

        // Stack arithmetic leaves CC alone
        apply("call",    1'b0, CALL, 4'h0, 64'd10, 64'd50, 64'd20, 64'd42, 1'b0);
        apply("jne_call",1'b0, JXX, NE,   64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        apply("ret",     1'b0, RET, 4'h0, 64'd0, 64'd50, 64'd0, 64'd58, 1'b0);
        apply("push",    1'b0, PUSHQ, 4'h0, 64'd0, 64'd16, 64'd0, 64'd8, 1'b0);
        apply("pop",     1'b0, POPQ, 4'h0, 64'd0, 64'd16, 64'd0, 64'd24, 1'b0);

        // Negative result
        apply("sub_neg", 1'b0, OPQ, SUB,  64'd50, 64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFD8, 1'b0);
        apply("jl_neg",  1'b0, JXX, L,    64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        apply("jg_neg",  1'b0, JXX, G,    64'd0, 64'd0, 64'd0, 64'd0, 1'b0);

        // Signed overflow on add: SF=1, OF=1 so SF^OF=0
        apply("add_ovf", 1'b0, OPQ, ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        apply("jge_ovf", 1'b0, JXX, GE,   64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        apply("jle_ovf", 1'b0, JXX, LE,   64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        apply("cmovl",   1'b0, CMOVXX, L, 64'd77, 64'd0, 64'd0, 64'd77, 1'b0);

        // Unsupported OPq function: zero result, flags kept
        apply("opq_f4",  1'b0, OPQ, 4'h4, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        apply("jge_keep",1'b0, JXX, GE,   64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        apply("jne_keep",1'b0, JXX, NE,   64'd0, 64'd0, 64'd0, 64'd0, 1'b1);

        // Moves, xor-to-zero, reset winning over an OPq
        apply("rmmovq",  1'b0, RMMOVQ, 4'h0, 64'd0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF8, 64'd92, 1'b0);
        apply("mrmovq",  1'b0, MRMOVQ, 4'h0, 64'd0, 64'd100, 64'd4, 64'd104, 1'b0);
        apply("irmovq",  1'b0, IRMOVQ, 4'h0, 64'd0, 64'd0, 64'd7, 64'd7, 1'b0);
        apply("xor0",    1'b0, OPQ, XOR,  64'h55, 64'h55, 64'd0, 64'd0, 1'b0);
        apply("je_xor",  1'b0, JXX, E,    64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        apply("and",     1'b0, OPQ, AND,  64'hF0F0, 64'h0FF0, 64'd0, 64'h00F0, 1'b0);
        apply("jne_and", 1'b0, JXX, NE,   64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        apply("rst_opq", 1'b1, OPQ, SUB,  64'd5, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        apply("je_rst2", 1'b0, JXX, E,    64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        apply("jl_rst2", 1'b0, JXX, L,    64'd0, 64'd0, 64'd0, 64'd0, 1'b0);

        // Odd encodings
        apply("invalid", 1'b0, 4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 64'd0, 1'b0);
        apply("jxx_f7",  1'b0, JXX, 4'h7, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        apply("cmov",    1'b0, CMOVXX, ALWAYS, 64'd123, 64'd9, 64'd9, 64'd123, 1'b1);
        apply("halt",    1'b0, HALT, 4'h0, 64'd5, 64'd6, 64'd7, 64'd0, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            ic = 4'($urandom_range(0, 15));
            fn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 4) == 0) ? a : {$urandom, $urandom};
            c  = {$urandom, $urandom};
            r  = ($urandom_range(0, 19) == 0);
            apply("rand", r, ic, fn, a, b, c, model_val_e(ic, fn, a, b, c),
                  model_cnd(ic, fn, m_zf, m_sf, m_of));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
